// File: rtl/apu_pkg.sv
// Shared APU frame-counter constants, $4017 bit positions and mode type.
package apu_pkg;

  localparam int STEP_Q1    = 7457;
  localparam int STEP_Q2    = 14913;
  localparam int STEP_Q3    = 22371;
  localparam int STEP4_LAST = 29829;
  localparam int STEP5_LAST = 37281;

  localparam int MODE_BIT    = 7;
  localparam int INHIBIT_BIT = 6;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } mode_e;

endpackage

// File: rtl/frame_step_decode.sv
// Combinational step match of the frame counter against the active mode.
module frame_step_decode
  import apu_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int STEP_Q1    = apu_pkg::STEP_Q1,
  parameter int STEP_Q2    = apu_pkg::STEP_Q2,
  parameter int STEP_Q3    = apu_pkg::STEP_Q3,
  parameter int STEP4_LAST = apu_pkg::STEP4_LAST,
  parameter int STEP5_LAST = apu_pkg::STEP5_LAST
) (
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  mode_e                mode_i,
  output logic                 quarter_hit_o,
  output logic                 half_hit_o,
  output logic                 last_hit_o,
  output logic                 irq_hit_o
);

  localparam logic [CNT_WIDTH-1:0] Q1 = CNT_WIDTH'(STEP_Q1);
  localparam logic [CNT_WIDTH-1:0] Q2 = CNT_WIDTH'(STEP_Q2);
  localparam logic [CNT_WIDTH-1:0] Q3 = CNT_WIDTH'(STEP_Q3);
  localparam logic [CNT_WIDTH-1:0] L4 = CNT_WIDTH'(STEP4_LAST);
  localparam logic [CNT_WIDTH-1:0] L5 = CNT_WIDTH'(STEP5_LAST);

  logic q1, q2, q3, l4, l5;

  assign q1 = (cnt_i == Q1);
  assign q2 = (cnt_i == Q2);
  assign q3 = (cnt_i == Q3);
  assign l4 = (cnt_i == L4);
  assign l5 = (cnt_i == L5);

  assign last_hit_o    = (mode_i == MODE_5STEP) ? l5 : l4;
  assign quarter_hit_o = q1 | q2 | q3 | last_hit_o;
  assign half_hit_o    = q2 | last_hit_o;
  assign irq_hit_o     = (mode_i == MODE_4STEP) & l4;

endmodule

// File: rtl/frame_sequencer.sv
// APU frame sequencer: quarter/half-frame strobes, $4017 mode and frame IRQ.
// Optional IRQ logic is built only when FRAME_IRQ_EN is defined.
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int STEP_Q1    = apu_pkg::STEP_Q1,
  parameter int STEP_Q2    = apu_pkg::STEP_Q2,
  parameter int STEP_Q3    = apu_pkg::STEP_Q3,
  parameter int STEP4_LAST = apu_pkg::STEP4_LAST,
  parameter int STEP5_LAST = apu_pkg::STEP5_LAST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reg_4017,
  input  logic       reg_4017_event,
  input  logic       status_read,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  mode_e                mode_q;
  logic                 q240_q, q120_q;
  logic                 quarter_hit, half_hit, last_hit, irq_hit;

  frame_step_decode #(
    .CNT_WIDTH (CNT_WIDTH),
    .STEP_Q1   (STEP_Q1),
    .STEP_Q2   (STEP_Q2),
    .STEP_Q3   (STEP_Q3),
    .STEP4_LAST(STEP4_LAST),
    .STEP5_LAST(STEP5_LAST)
  ) u_decode (
    .cnt_i        (cnt_q),
    .mode_i       (mode_q),
    .quarter_hit_o(quarter_hit),
    .half_hit_o   (half_hit),
    .last_hit_o   (last_hit),
    .irq_hit_o    (irq_hit)
  );

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (reg_4017_event || last_hit) cnt_d = '0;
  end

  // A write overrides any step match; 5-step writes clock immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      mode_q <= MODE_4STEP;
      q240_q <= 1'b0;
      q120_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (reg_4017_event) begin
        mode_q <= mode_e'(reg_4017[MODE_BIT]);
        q240_q <= reg_4017[MODE_BIT];
        q120_q <= reg_4017[MODE_BIT];
      end else begin
        q240_q <= quarter_hit;
        q120_q <= half_hit;
      end
    end
  end

  assign enable_240hz = q240_q;
  assign enable_120hz = q120_q;

`ifdef FRAME_IRQ_EN
  logic inhibit_q, irq_q;
  logic unused_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (reg_4017_event) inhibit_q <= reg_4017[INHIBIT_BIT];
      if (irq_hit && !inhibit_q && !reg_4017_event)
        irq_q <= 1'b1;
      else if (status_read || (reg_4017_event && reg_4017[INHIBIT_BIT]))
        irq_q <= 1'b0;
    end
  end

  assign frame_irq   = irq_q;
  assign unused_bits = ^reg_4017[5:0];
`else
  logic unused_bits;

  assign frame_irq   = 1'b0;
  assign unused_bits = ^{reg_4017[5:0], reg_4017[INHIBIT_BIT],
                         status_read, irq_hit};
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench: a full-size instance for spec timing, a scaled one for control paths.
module tb_frame_sequencer;

`ifdef FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam int Q1 = 20;
  localparam int Q2 = 41;
  localparam int Q3 = 63;
  localparam int L4 = 83;
  localparam int L5 = 107;
  localparam int P4 = L4 + 1;
  localparam int P5 = L5 + 1;
  localparam int R  = 2;

  logic       clk = 1'b0;
  logic       s_rst = 1'b1, s_ev = 1'b0, s_rd = 1'b0;
  logic [7:0] s_reg = 8'h00;
  logic       s_q, s_h, s_irq;
  logic       f_rst = 1'b1;
  logic       f_q, f_h, f_irq;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int s240 = 0, s120 = 0, f240 = 0, f120 = 0;
  bit s_irqseen = 1'b0;

  int         sc[$];
  string      st[$];
  logic [2:0] se[$];
  int         fc[$];
  string      ft[$];
  logic [2:0] fe[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_sequencer #(
    .CNT_WIDTH (16),
    .STEP_Q1   (Q1),
    .STEP_Q2   (Q2),
    .STEP_Q3   (Q3),
    .STEP4_LAST(L4),
    .STEP5_LAST(L5)
  ) dut (
    .clk           (clk),
    .rst           (s_rst),
    .reg_4017      (s_reg),
    .reg_4017_event(s_ev),
    .status_read   (s_rd),
    .enable_240hz  (s_q),
    .enable_120hz  (s_h),
    .frame_irq     (s_irq)
  );

  frame_sequencer dut_full (
    .clk           (clk),
    .rst           (f_rst),
    .reg_4017      (8'h00),
    .reg_4017_event(1'b0),
    .status_read   (1'b0),
    .enable_240hz  (f_q),
    .enable_120hz  (f_h),
    .frame_irq     (f_irq)
  );

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic exp_s(input int c, input string t,
                       input logic q, input logic h, input logic i);
    sc.push_back(c);
    st.push_back(t);
    se.push_back({q, h, i & IRQ_EN});
  endtask

  task automatic exp_f(input int c, input string t,
                       input logic q, input logic h, input logic i);
    fc.push_back(c);
    ft.push_back(t);
    fe.push_back({q, h, i & IRQ_EN});
  endtask

  always @(negedge clk) begin
    if (s_q) s240++;
    if (s_h) s120++;
    if (s_irq) s_irqseen = 1'b1;
    if (f_q) f240++;
    if (f_h) f120++;
    while (sc.size() != 0 && sc[0] <= cyc) begin
      check(st[0], int'({s_q, s_h, s_irq}), int'(se[0]));
      void'(sc.pop_front());
      void'(st.pop_front());
      void'(se.pop_front());
    end
    while (fc.size() != 0 && fc[0] <= cyc) begin
      check(ft[0], int'({f_q, f_h, f_irq}), int'(fe[0]));
      void'(fc.pop_front());
      void'(ft.pop_front());
      void'(fe.pop_front());
    end
  end

  task automatic step_to(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  task automatic wr(input int x, input logic [7:0] v);
    step_to(x - 1);
    s_reg = v;
    s_ev  = 1'b1;
    step_to(x);
    s_ev  = 1'b0;
  endtask

  task automatic rd(input int x);
    step_to(x - 1);
    s_rd = 1'b1;
    step_to(x);
    s_rd = 1'b0;
  endtask

  initial begin
    int a, w, w2, w3, w4, w5, w6, x, y, z, v;
    int n4, n2;

    // Full-size instance: real step constants from reset release.
    exp_f(R,         "f_rst",  0, 0, 0);
    exp_f(R + 7457,  "f_pre",  0, 0, 0);
    exp_f(R + 7458,  "f_q1",   1, 0, 0);
    exp_f(R + 7459,  "f_q1e",  0, 0, 0);
    exp_f(R + 14914, "f_q2",   1, 1, 0);
    exp_f(R + 22372, "f_q3",   1, 0, 0);
    exp_f(R + 29829, "f_l4p",  0, 0, 0);
    exp_f(R + 29830, "f_l4",   1, 1, 1);
    exp_f(R + 37288, "f_wrap", 1, 0, 1);

    // Scaled instance, scenario 1: reset release, one 4-step frame.
    exp_s(R,              "s1_rst",  0, 0, 0);
    exp_s(R + 1,          "s1_r1",   0, 0, 0);
    exp_s(R + Q1,         "s1_pre",  0, 0, 0);
    exp_s(R + Q1 + 1,     "s1_q1",   1, 0, 0);
    exp_s(R + Q2 + 1,     "s1_q2",   1, 1, 0);
    exp_s(R + Q3 + 1,     "s1_q3",   1, 0, 0);
    exp_s(R + P4,         "s1_l4",   1, 1, 1);
    exp_s(R + P4 + Q1 + 1,"s1_wrap", 1, 0, 1);

    step_to(R);
    s_rst = 1'b0;
    f_rst = 1'b0;
    n4 = s240;
    n2 = s120;
    step_to(R + P4 + Q1 + 1);
    check("s1_n240", s240 - n4, 5);
    check("s1_n120", s120 - n2, 2);

    // Scenario 2: clear IRQ, then switch to 5-step mid-frame.
    a = R + P4 + Q1 + 4;
    w = a + 5;
    exp_s(a,            "s2_rdclr", 0, 0, 0);
    exp_s(w,            "s2_imm",   1, 1, 0);
    exp_s(w + 1,        "s2_imme",  0, 0, 0);
    exp_s(w + Q1 + 1,   "s2_q1",    1, 0, 0);
    exp_s(w + Q2 + 1,   "s2_q2",    1, 1, 0);
    exp_s(w + Q3 + 1,   "s2_q3",    1, 0, 0);
    exp_s(w + L4 + 1,   "s2_no4",   0, 0, 0);
    exp_s(w + P5,       "s2_l5",    1, 1, 0);
    exp_s(w + 2 * P5,   "s2_l5b",   1, 1, 0);
    rd(a);
    step_to(w - 1);
    n4 = s240;
    n2 = s120;
    s_irqseen = 1'b0;
    wr(w, 8'h80);
    step_to(w + 2 * P5);
    check("s2_n240", s240 - n4, 9);
    check("s2_n120", s120 - n2, 5);
    check("s2_noirq", int'(s_irqseen), 0);

    // Scenario 3: inhibit blocks IRQ; clearing inhibit re-enables it.
    w2 = w + 2 * P5 + 3;
    w3 = w2 + P4 + 5;
    w4 = w3 + P4 + 4;
    exp_s(w2,      "s3_wr40",  0, 0, 0);
    exp_s(w2 + P4, "s3_inh",   1, 1, 0);
    exp_s(w3,      "s3_wr00",  0, 0, 0);
    exp_s(w3 + P4, "s3_set",   1, 1, 1);
    exp_s(w4 - 1,  "s3_pend",  0, 0, 1);
    exp_s(w4,      "s3_wrclr", 0, 0, 0);
    wr(w2, 8'h40);
    wr(w3, 8'h00);
    wr(w4, 8'h40);

    // Scenario 4: status_read clears; read in the set cycle loses.
    w5 = w4 + 3;
    w6 = w5 + 2 * P4;
    exp_s(w5,          "s4_wr00",  0, 0, 0);
    exp_s(w5 + P4,     "s4_set",   1, 1, 1);
    exp_s(w5 + P4 + 3, "s4_rdclr", 0, 0, 0);
    exp_s(w6,          "s4_setwin",1, 1, 1);
    exp_s(w6 + 1,      "s4_hold",  0, 0, 1);
    wr(w5, 8'h00);
    rd(w5 + P4 + 3);
    rd(w6);

    // Scenario 5: write lands on the STEP_Q2 cycle and suppresses it.
    x = w6 + Q2 + 1;
    exp_s(x,          "s5_supp", 0, 0, 1);
    exp_s(x + Q1,     "s5_pre",  0, 0, 1);
    exp_s(x + Q1 + 1, "s5_q1",   1, 0, 1);
    step_to(x - 1);
    n4 = s240;
    n2 = s120;
    wr(x, 8'h00);
    step_to(x + Q1 + 1);
    check("s5_n240", s240 - n4, 1);
    check("s5_n120", s120 - n2, 0);

    // Scenario 6: reset mid-frame in 5-step with IRQ pending.
    y = x + Q1 + 4;
    z = y + Q3;
    exp_s(y,          "s6_imm",   1, 1, 1);
    exp_s(z - 1,      "s6_pre",   0, 0, 1);
    exp_s(z,          "s6_rst",   0, 0, 0);
    exp_s(z + 1,      "s6_rst1",  0, 0, 0);
    exp_s(z + Q1 + 1, "s6_q1",    1, 0, 0);
    exp_s(z + P4,     "s6_mode4", 1, 1, 1);
    wr(y, 8'h80);
    step_to(z - 1);
    s_rst = 1'b1;
    step_to(z);
    s_rst = 1'b0;

    // Scenario 7: write (bit 6 low) and status_read together.
    v = z + P4 + 5;
    exp_s(v, "s7_both", 0, 0, 0);
    step_to(v - 1);
    s_reg = 8'h00;
    s_ev  = 1'b1;
    s_rd  = 1'b1;
    step_to(v);
    s_ev  = 1'b0;
    s_rd  = 1'b0;

    step_to(R + 37295);
    check("f_n240", f240, 5);
    check("f_n120", f120, 2);
    check("s_left", sc.size(), 0);
    check("f_left", fc.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
